// File: rtl/scanner_pkg.sv
// Shared types and constants for the nonce result scanner.
package scanner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_e;

    localparam int          NUM_NONCES_DEFAULT = 16;
    localparam logic [31:0] BEST_HASH_RST      = 32'hFFFF_FFFF;

endpackage

// File: rtl/scan_min_tracker.sv
// Running minimum (value + index), strict hit comparator and hit counter
// over the stream of result words read back from memory.
module scan_min_tracker
    import scanner_pkg::*;
#(
    parameter int NUM_NONCES = NUM_NONCES_DEFAULT,
    parameter int NW         = $clog2(NUM_NONCES)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          valid,
    input  logic [NW-1:0] idx,
    input  logic [31:0]   word,
    input  logic [31:0]   target,
    output logic [NW:0]   hit_count,
    output logic          found,
    output logic [NW-1:0] best_nonce,
    output logic [31:0]   best_hash
);

    logic          hit_s;
    logic          take_s;
    logic [NW:0]   hit_next_s;
    logic [NW:0]   hit_count_r;
    logic          found_r;
    logic [NW-1:0] best_nonce_r;
    logic [31:0]   best_hash_r;

    // Hit test and best-candidate selection; index 0 always seeds the minimum
    always_comb begin
        hit_s      = (word < target);
        hit_next_s = hit_count_r + (hit_s ? (NW+1)'(1) : (NW+1)'(0));
        take_s     = (idx == {NW{1'b0}}) || (word < best_hash_r);
    end

    // Result registers; found is derived from the same next count so both move together
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count_r  <= {(NW+1){1'b0}};
            found_r      <= 1'b0;
            best_nonce_r <= {NW{1'b0}};
            best_hash_r  <= BEST_HASH_RST;
        end else if (clear) begin
            hit_count_r  <= {(NW+1){1'b0}};
            found_r      <= 1'b0;
        end else if (valid) begin
            hit_count_r  <= hit_next_s;
            found_r      <= (hit_next_s != {(NW+1){1'b0}});
            if (take_s) begin
                best_hash_r  <= word;
                best_nonce_r <= idx;
            end
        end
    end

    assign hit_count  = hit_count_r;
    assign found      = found_r;
    assign best_nonce = best_nonce_r;
    assign best_hash  = best_hash_r;

endmodule

// File: rtl/nonce_result_scanner.sv
// Read-back master: fetches NUM_NONCES result words after the hash block finishes
// and reports hit count plus the minimum hash and its nonce index.
module nonce_result_scanner
    import scanner_pkg::*;
#(
    parameter int NUM_NONCES = NUM_NONCES_DEFAULT,
    parameter int NW         = $clog2(NUM_NONCES)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [15:0]   result_addr,
    input  logic [31:0]   target,
    output logic          mem_clk,
    output logic          mem_we,
    output logic [15:0]   mem_addr,
    input  logic [31:0]   mem_read_data,
    output logic          done,
    output logic          found,
    output logic [NW:0]   hit_count,
    output logic [NW-1:0] best_nonce,
    output logic [31:0]   best_hash
);

    scan_state_e   state_r;
    logic [15:0]   base_r;
    logic [31:0]   target_r;
    logic [15:0]   mem_addr_r;
    logic [NW-1:0] idx_r;
    logic          done_r;

    logic          accept_s;
    logic          scan_valid_s;
    logic          last_s;
    logic          more_s;
    logic [15:0]   next_addr_s;

    // Start acceptance, last-word detection and look-ahead address (two words ahead of idx)
    always_comb begin
        accept_s     = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        scan_valid_s = (state_r == ST_SCAN);
        last_s       = (idx_r == NW'(NUM_NONCES - 1));
        more_s       = ((int'(idx_r) + 2) < NUM_NONCES);
        next_addr_s  = base_r + 16'(idx_r) + 16'd2;
    end

    // Scan sequencer and address generator
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            base_r     <= 16'd0;
            target_r   <= 32'd0;
            mem_addr_r <= 16'd0;
            idx_r      <= {NW{1'b0}};
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        base_r     <= result_addr;
                        target_r   <= target;
                        mem_addr_r <= result_addr;
                        idx_r      <= {NW{1'b0}};
                        done_r     <= 1'b0;
                        state_r    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    mem_addr_r <= base_r + 16'd1;
                    state_r    <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (more_s) begin
                        mem_addr_r <= next_addr_s;
                    end
                    if (last_s) begin
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        idx_r <= idx_r + NW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    scan_min_tracker #(
        .NUM_NONCES (NUM_NONCES),
        .NW         (NW)
    ) u_tracker (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (accept_s),
        .valid      (scan_valid_s),
        .idx        (idx_r),
        .word       (mem_read_data),
        .target     (target_r),
        .hit_count  (hit_count),
        .found      (found),
        .best_nonce (best_nonce),
        .best_hash  (best_hash)
    );

    assign mem_clk  = clk;
    assign mem_we   = 1'b0;
    assign mem_addr = mem_addr_r;
    assign done     = done_r;

endmodule

// File: tb/tb_nonce_result_scanner.sv
// Directed bench for nonce_result_scanner with a synchronous-read memory model.
module tb_nonce_result_scanner;

    localparam int NN = 16;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   result_addr = 16'd0;
    logic [31:0]   target = 32'd0;
    logic          mem_clk;
    logic          mem_we;
    logic [15:0]   mem_addr;
    logic [31:0]   mem_read_data = 32'd0;
    logic          done;
    logic          found;
    logic [NW:0]   hit_count;
    logic [NW-1:0] best_nonce;
    logic [31:0]   best_hash;

    logic [31:0]   mem [0:65535];

    int n_checks = 0;
    int n_fail   = 0;

    nonce_result_scanner #(.NUM_NONCES(NN), .NW(NW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .result_addr   (result_addr),
        .target        (target),
        .mem_clk       (mem_clk),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_read_data (mem_read_data),
        .done          (done),
        .found         (found),
        .hit_count     (hit_count),
        .best_nonce    (best_nonce),
        .best_hash     (best_hash)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_read_data <= mem[mem_addr];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_done"},  32'(done), 32'd0);
        check_eq({tag, "_found"}, 32'(found), 32'd0);
        check_eq({tag, "_hits"},  32'(hit_count), 32'd0);
        check_eq({tag, "_nonce"}, 32'(best_nonce), 32'd0);
        check_eq({tag, "_hash"},  best_hash, 32'hFFFF_FFFF);
        check_eq({tag, "_addr"},  32'(mem_addr), 32'd0);
        check_eq({tag, "_we"},    32'(mem_we), 32'd0);
    endtask

    task automatic run_scan(input string tag, input logic [15:0] addr, input logic [31:0] tgt,
                            input bit hold, input logic [31:0] exp_hits,
                            input logic [31:0] exp_nonce, input logic [31:0] exp_hash);
        logic [15:0] addrs [$];
        int cyc;
        bit we_seen;
        cyc = 0;
        we_seen = 1'b0;
        @(negedge clk);
        result_addr = addr;
        target      = tgt;
        start       = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        check_eq({tag, "_done_drop"}, 32'(done), 32'd0);
        check_eq({tag, "_addr0"}, 32'(mem_addr), 32'(addr));
        addrs.push_back(mem_addr);
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (mem_addr != addrs[$]) addrs.push_back(mem_addr);
            if (mem_we) we_seen = 1'b1;
        end
        start = 1'b0;
        check_eq({tag, "_latency"}, 32'(cyc), 32'd17);
        check_eq({tag, "_done"},    32'(done), 32'd1);
        check_eq({tag, "_hits"},    32'(hit_count), exp_hits);
        check_eq({tag, "_found"},   32'(found), (exp_hits != 32'd0) ? 32'd1 : 32'd0);
        check_eq({tag, "_nonce"},   32'(best_nonce), exp_nonce);
        check_eq({tag, "_hash"},    best_hash, exp_hash);
        check_eq({tag, "_nreads"},  32'(addrs.size()), 32'd16);
        check_eq({tag, "_we"},      32'(we_seen), 32'd0);
        for (int i = 0; i < addrs.size() && i < NN; i++) begin
            logic [15:0] ea;
            ea = addr + 16'(i);
            check_eq($sformatf("%s_raddr%0d", tag, i), 32'(addrs[i]), 32'(ea));
        end
        // results must stay put in DONE
        @(posedge clk); #1;
        check_eq({tag, "_hold_done"}, 32'(done), 32'd1);
        check_eq({tag, "_hold_hash"}, best_hash, exp_hash);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'd0;
        for (int i = 0; i < NN; i++) begin
            mem[16'h0300 + i] = 32'hFFFF_FFFF;                  // all misses
            mem[16'h0100 + i] = 32'h0001_0000 - 32'(i);         // descending
            mem[16'h0400 + i] = 32'h0000_0100 + 32'(i);         // tie case base
            mem[16'h0200 + i] = 32'(i);                         // every word hits
        end
        mem[16'h0405] = 32'h0000_0003;
        mem[16'h040B] = 32'h0000_0003;
        for (int i = 0; i < NN; i++) begin
            logic [15:0] a;
            a = 16'hFFFE + 16'(i);
            mem[a] = (i == 3) ? 32'h0000_0010 : 32'h0000_1000 + 32'(16 * i);
        end

        #12;
        check_reset_values("por");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_values("idle");

        run_scan("allmiss", 16'h0300, 32'h0000_1000, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFFF);
        run_scan("desc",    16'h0100, 32'h0000_FFF8, 1'b0, 32'd7, 32'd15, 32'h0000_FFF1);
        run_scan("tie",     16'h0400, 32'h0000_0003, 1'b0, 32'd0, 32'd5, 32'h0000_0003);
        run_scan("wrap",    16'hFFFE, 32'h0000_1020, 1'b0, 32'd3, 32'd3, 32'h0000_0010);

        // abort mid-scan: reset while idx==8
        @(negedge clk);
        result_addr = 16'h0200;
        target      = 32'd100;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        check_eq("abort_prehits", 32'(hit_count), 32'd8);
        reset_n = 1'b0;
        #1;
        check_reset_values("abort");
        @(negedge clk);
        check_reset_values("abort_held");
        reset_n = 1'b1;
        run_scan("after_rst", 16'h0100, 32'h0000_FFF8, 1'b0, 32'd7, 32'd15, 32'h0000_FFF1);

        // start held through the whole scan, then a restart issued from DONE
        run_scan("held",    16'h0400, 32'h0000_0003, 1'b1, 32'd0, 32'd5, 32'h0000_0003);
        run_scan("restart", 16'h0400, 32'h0000_0003, 1'b0, 32'd0, 32'd5, 32'h0000_0003);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
